// File: rtl/tmr_result_fifo.sv
// Result FIFO behind the TMR voter: first-word-fall-through storage of {TMR_error, data} words,
// with a saturating error counter and an intake halt after the first accepted error-tagged word.
module tmr_result_fifo #(
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_LEN-1:0]  data_in,
    input  logic                 in_valid,
    input  logic                 TMR_error,
    input  logic                 halt_clr,
    output logic [DATA_LEN-1:0]  out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 full,
    output logic                 halted,
    output logic                 drop_flag,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_LEN-1:0] mem_data [DEPTH];
    logic                mem_err  [DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                push;
    logic                pop;
    logic [DATA_LEN-1:0] head_data_next;
    logic                head_err_next;

    // full/halted are the registered values, so intake never depends on a same-cycle pop
    assign push = in_valid & ~full & ~halted;
    assign pop  = out_valid & out_ready;

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (push) begin
            wr_ptr_next = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
        end
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Head word for next cycle; the word being written is the head only when it lands on rd_ptr_next
    always_comb begin
        head_data_next = '0;
        head_err_next  = 1'b0;
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_ptr_next)) begin
                head_data_next = data_in;
                head_err_next  = TMR_error;
            end else begin
                head_data_next = mem_data[rd_ptr_next];
                head_err_next  = mem_err[rd_ptr_next];
            end
        end
    end

    // Intake control FSM
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (push && TMR_error) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (halt_clr && (count == '0)) begin
                    state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Storage array carries no reset; the valid window is defined by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= data_in;
            mem_err[wr_ptr]  <= TMR_error;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
            halted    <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            full      <= (count_next == CNT_W'(DEPTH));
            halted    <= (state_next == HALT);
            out_data  <= head_data_next;
            out_err   <= head_err_next;
        end
    end

    // Sticky drop indication and saturating error count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_flag <= 1'b0;
            err_count <= '0;
        end else begin
            if (in_valid && (full || halted)) begin
                drop_flag <= 1'b1;
            end
            if (push && TMR_error && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tmr_result_fifo.sv
// Bench for tmr_result_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model.
module tb_tmr_result_fifo;

    localparam int unsigned DATA_LEN  = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned ERR_CNT_W = 4;
    localparam int          ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [DATA_LEN-1:0]  data_in = '0;
    logic                 in_valid = 1'b0;
    logic                 TMR_error = 1'b0;
    logic                 halt_clr = 1'b0;
    logic                 out_ready = 1'b0;
    logic [DATA_LEN-1:0]  out_data;
    logic                 out_err;
    logic                 out_valid;
    logic                 full;
    logic                 halted;
    logic                 drop_flag;
    logic [ERR_CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    tmr_result_fifo #(
        .DATA_LEN (DATA_LEN),
        .DEPTH    (DEPTH),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .TMR_error(TMR_error),
        .halt_clr (halt_clr),
        .out_data (out_data),
        .out_err  (out_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .full     (full),
        .halted   (halted),
        .drop_flag(drop_flag),
        .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: entries are {err, data}
    logic [DATA_LEN:0] mq[$];
    bit                m_halt = 1'b0;
    bit                m_drop = 1'b0;
    int                m_errs = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_halt = 1'b0;
            m_drop = 1'b0;
            m_errs = 0;
        end else begin
            bit do_push;
            bit do_pop;
            int sz;
            sz      = mq.size();
            do_push = in_valid && (sz < DEPTH) && !m_halt;
            do_pop  = (sz > 0) && out_ready;
            if (in_valid && ((sz == DEPTH) || m_halt)) m_drop = 1'b1;
            if (!m_halt && do_push && TMR_error) m_halt = 1'b1;
            else if (m_halt && halt_clr && (sz == 0)) m_halt = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({TMR_error, data_in});
                if (TMR_error && (m_errs < ERR_MAX)) m_errs++;
            end
        end
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("halted", 32'(halted), 32'(m_halt));
            check("drop_flag", 32'(drop_flag), 32'(m_drop));
            check("err_count", 32'(err_count), 32'(m_errs));
            if (mq.size() != 0) begin
                check("out_data", 32'(out_data), 32'(mq[0][DATA_LEN-1:0]));
                check("out_err", 32'(out_err), 32'(mq[0][DATA_LEN]));
            end else begin
                check("out_data_empty", 32'(out_data), 32'd0);
                check("out_err_empty", 32'(out_err), 32'd0);
            end
        end
    end

    task automatic cyc(input logic iv, input logic [DATA_LEN-1:0] d, input logic e,
                       input logic rdy, input logic hc);
        in_valid  = iv;
        data_in   = d;
        TMR_error = e;
        out_ready = rdy;
        halt_clr  = hc;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy, input logic hc);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, rdy, hc);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;

        // In-order delivery with one-cycle latency
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_data", 32'(out_data), 32'h11);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t1_second_data", 32'(out_data), 32'h22);
        idle(4, 1'b1, 1'b0);
        check("t1_halted", 32'(halted), 32'd0);

        // Overflow: fifth word dropped
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_drop", 32'(drop_flag), 32'd1);

        // Full with simultaneous input and pop: pop only
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("t3_not_full", 32'(full), 32'd0);
        check("t3_head", 32'(out_data), 32'h41);
        idle(5, 1'b1, 1'b0);

        // Error entry halts intake until drained and cleared
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_err_count", 32'(err_count), 32'd1);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t4_clr_ignored", 32'(halted), 32'd1);
        check("t4_head_err", 32'(out_err), 32'd1);
        check("t4_head_data", 32'(out_data), 32'hA5);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t4_resumed", 32'(halted), 32'd0);

        // Error counter saturation
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            idle(4, 1'b1, 1'b1);
        end
        check("t5_err_sat", 32'(err_count), 32'(ERR_MAX));
        check("t5_run", 32'(halted), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) == 0));
        end

        // Async reset mid-pop with three entries held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_full", 32'(full), 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        check("t6_err_count", 32'(err_count), 32'd0);
        check("t6_drop", 32'(drop_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        check("t6_first_data", 32'(out_data), 32'h5C);
        check("t6_first_valid", 32'(out_valid), 32'd1);
        idle(3, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
